// File: rtl/spi_target_xcvr.sv
// SPI mode-0 target transceiver: oversampled SCK/CS/MOSI, one-byte TX holding
// register feeding an MSB-first shift register, MSB-first RX with per-byte strobe.
module spi_target_xcvr #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sck_i,
  input  logic       cs_n_i,
  input  logic       mosi_i,
  output logic       miso_o,
  output logic       miso_oe_o,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       tx_underrun
);

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_e;

  logic [SYNC_STAGES-1:0] sck_sync_q;
  logic [SYNC_STAGES-1:0] cs_sync_q;
  logic [SYNC_STAGES-1:0] mosi_sync_q;
  logic                   sck_dly_q;

  logic sck_s;
  logic cs_s;
  logic mosi_s;
  logic sck_rise;
  logic sck_fall;

  state_e     state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] rx_shift_q, rx_shift_d;
  logic [7:0] tx_shift_q, tx_shift_d;
  logic [7:0] hold_q, hold_d;
  logic       hold_full_q, hold_full_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_valid_q, rx_valid_d;
  logic       underrun_q, underrun_d;
  logic       miso_q, miso_d;
  logic       miso_oe_q, miso_oe_d;

  logic       load;
  logic       tx_wr;

  assign sck_s    = sck_sync_q[SYNC_STAGES-1];
  assign cs_s     = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync_q[SYNC_STAGES-1];
  assign sck_rise = sck_s & ~sck_dly_q;
  assign sck_fall = ~sck_s & sck_dly_q;

  // Idle line levels are the reset presets so no spurious edge appears after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sck_sync_q  <= '0;
      cs_sync_q   <= '1;
      mosi_sync_q <= '0;
      sck_dly_q   <= 1'b0;
    end else begin
      sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], sck_i};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs_n_i};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi_i};
      sck_dly_q   <= sck_s;
    end
  end

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    rx_shift_d = rx_shift_q;
    tx_shift_d = tx_shift_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    underrun_d = 1'b0;
    load       = 1'b0;
    tx_wr      = tx_valid & ~hold_full_q;

    case (state_q)
      IDLE: begin
        if (!cs_s) begin
          state_d    = ACTIVE;
          bit_cnt_d  = 3'd0;
          rx_shift_d = 8'h00;
          load       = 1'b1;
        end
      end
      ACTIVE: begin
        // Deselect wins over a coincident SCK edge, so a final falling edge
        // that arrives together with CS rising never consumes the holding byte.
        if (cs_s) begin
          state_d    = IDLE;
          bit_cnt_d  = 3'd0;
          rx_shift_d = 8'h00;
          tx_shift_d = 8'h00;
        end else if (sck_rise) begin
          rx_shift_d = {rx_shift_q[6:0], mosi_s};
          bit_cnt_d  = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            rx_data_d  = {rx_shift_q[6:0], mosi_s};
            rx_valid_d = 1'b1;
          end
        end else if (sck_fall) begin
          if (bit_cnt_q == 3'd0) begin
            load = 1'b1;
          end else begin
            tx_shift_d = {tx_shift_q[6:0], 1'b0};
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // A load observes the holding register before any same-cycle write.
    if (load) begin
      tx_shift_d = hold_full_q ? hold_q : 8'h00;
      underrun_d = ~hold_full_q;
    end

    hold_full_d = tx_wr ? 1'b1 : (load ? 1'b0 : hold_full_q);
    hold_d      = tx_wr ? tx_data : hold_q;
    miso_oe_d   = (state_d == ACTIVE);
    miso_d      = (state_d == ACTIVE) ? tx_shift_d[7] : 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      bit_cnt_q   <= 3'd0;
      rx_shift_q  <= 8'h00;
      tx_shift_q  <= 8'h00;
      hold_q      <= 8'h00;
      hold_full_q <= 1'b0;
      rx_data_q   <= 8'h00;
      rx_valid_q  <= 1'b0;
      underrun_q  <= 1'b0;
      miso_q      <= 1'b0;
      miso_oe_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_shift_q  <= rx_shift_d;
      tx_shift_q  <= tx_shift_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      underrun_q  <= underrun_d;
      miso_q      <= miso_d;
      miso_oe_q   <= miso_oe_d;
    end
  end

  assign miso_o      = miso_q;
  assign miso_oe_o   = miso_oe_q;
  assign tx_ready    = ~hold_full_q;
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign tx_underrun = underrun_q;

endmodule

// File: tb/tb_spi_target_xcvr.sv
// Directed bench for spi_target_xcvr: drives a mode-0 controller at clk/8 and
// checks received bytes, MISO bit streams, holding-register and reset behaviour.
module tb_spi_target_xcvr;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sck_i = 1'b0;
  logic       cs_n_i = 1'b1;
  logic       mosi_i = 1'b0;
  logic       miso_o;
  logic       miso_oe_o;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       tx_underrun;

  int n_tests = 0;
  int n_fail  = 0;

  int         rx_cnt = 0;
  int         und_cnt = 0;
  logic [7:0] rx_last = 8'h00;
  logic [7:0] rx_prev = 8'h00;

  spi_target_xcvr #(.SYNC_STAGES(2)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .sck_i       (sck_i),
    .cs_n_i      (cs_n_i),
    .mosi_i      (mosi_i),
    .miso_o      (miso_o),
    .miso_oe_o   (miso_oe_o),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .tx_underrun (tx_underrun)
  );

  always #5 clk = ~clk;

  // Pulse monitor: each one-cycle strobe is seen by exactly one falling edge.
  always @(negedge clk) begin
    if (rx_valid) begin
      rx_cnt  <= rx_cnt + 1;
      rx_prev <= rx_last;
      rx_last <= rx_data;
    end
    if (tx_underrun) und_cnt <= und_cnt + 1;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d", n_tests);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic write_tx(input logic [7:0] d);
    @(negedge clk);
    tx_data  = d;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic cs_start();
    @(negedge clk);
    cs_n_i = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  // end_mode 0: last SCK fall together with CS rise; 1: last SCK fall only;
  // 2: leave SCK high after the last rising edge.
  task automatic shift_bits(input logic [7:0] mo, input int n, input int end_mode,
                            output logic [7:0] mi);
    mi = 8'h00;
    for (int i = 0; i < n; i++) begin
      mosi_i = mo[3'(7 - i)];
      repeat (4) @(negedge clk);
      mi[3'(7 - i)] = miso_o;
      sck_i = 1'b1;
      repeat (4) @(negedge clk);
      if (i == n - 1) begin
        if (end_mode == 0) begin
          sck_i  = 1'b0;
          cs_n_i = 1'b1;
        end else if (end_mode == 1) begin
          sck_i = 1'b0;
        end
      end else begin
        sck_i = 1'b0;
      end
    end
  endtask

  initial begin
    logic [7:0] mi;
    logic [7:0] mi2;
    int rx0;
    int und0;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_tx_ready", 32'(tx_ready), 32'd1);
    check("rst_rx_data", 32'(rx_data), 32'h00);
    check("rst_rx_valid", 32'(rx_valid), 32'd0);
    check("rst_underrun", 32'(tx_underrun), 32'd0);
    check("rst_miso", 32'(miso_o), 32'd0);
    check("rst_miso_oe", 32'(miso_oe_o), 32'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Single byte: TX 0xA5, RX 0x3C
    rx0 = rx_cnt; und0 = und_cnt;
    write_tx(8'hA5);
    check("a5_tx_ready_full", 32'(tx_ready), 32'd0);
    cs_start();
    check("a5_oe_active", 32'(miso_oe_o), 32'd1);
    check("a5_tx_ready_after_load", 32'(tx_ready), 32'd1);
    shift_bits(8'h3C, 8, 0, mi);
    repeat (4) @(negedge clk);
    check("a5_miso_byte", 32'(mi), 32'hA5);
    check("a5_rx_count", 32'(rx_cnt - rx0), 32'd1);
    check("a5_rx_data", 32'(rx_last), 32'h3C);
    check("a5_oe_idle", 32'(miso_oe_o), 32'd0);
    check("a5_no_underrun", 32'(und_cnt - und0), 32'd0);

    // Underrun: nothing written
    rx0 = rx_cnt; und0 = und_cnt;
    cs_start();
    shift_bits(8'h00, 8, 0, mi);
    repeat (4) @(negedge clk);
    check("ur_miso_zero", 32'(mi), 32'h00);
    check("ur_underrun_count", 32'(und_cnt - und0), 32'd1);
    check("ur_rx_count", 32'(rx_cnt - rx0), 32'd1);

    // Two bytes under one CS with a refill during byte 1
    rx0 = rx_cnt; und0 = und_cnt;
    write_tx(8'h11);
    cs_start();
    write_tx(8'h22);
    shift_bits(8'hDE, 8, 1, mi);
    shift_bits(8'hAD, 8, 0, mi2);
    repeat (4) @(negedge clk);
    check("b2b_miso_byte1", 32'(mi), 32'h11);
    check("b2b_miso_byte2", 32'(mi2), 32'h22);
    check("b2b_rx_count", 32'(rx_cnt - rx0), 32'd2);
    check("b2b_rx_byte1", 32'(rx_prev), 32'hDE);
    check("b2b_rx_byte2", 32'(rx_last), 32'hAD);
    check("b2b_no_underrun", 32'(und_cnt - und0), 32'd0);

    // CS abort after 5 bits; holding byte written mid-byte must survive
    rx0 = rx_cnt;
    cs_start();
    write_tx(8'h96);
    shift_bits(8'hFF, 5, 0, mi);
    repeat (4) @(negedge clk);
    check("abort_no_rx", 32'(rx_cnt - rx0), 32'd0);
    repeat (3) begin
      sck_i = 1'b1;
      repeat (4) @(negedge clk);
      sck_i = 1'b0;
      repeat (4) @(negedge clk);
    end
    check("idle_sck_no_rx", 32'(rx_cnt - rx0), 32'd0);
    check("idle_sck_oe", 32'(miso_oe_o), 32'd0);
    cs_start();
    shift_bits(8'h81, 8, 0, mi);
    repeat (4) @(negedge clk);
    check("abort_next_miso", 32'(mi), 32'h96);
    check("abort_next_rx_count", 32'(rx_cnt - rx0), 32'd1);
    check("abort_next_rx_data", 32'(rx_last), 32'h81);

    // Asynchronous reset after 4 bits
    rx0 = rx_cnt; und0 = und_cnt;
    write_tx(8'hF0);
    cs_start();
    shift_bits(8'h55, 4, 2, mi);
    check("arst_pre_miso", 32'(miso_o), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("arst_miso", 32'(miso_o), 32'd0);
    check("arst_oe", 32'(miso_oe_o), 32'd0);
    check("arst_tx_ready", 32'(tx_ready), 32'd1);
    check("arst_rx_valid", 32'(rx_valid), 32'd0);
    check("arst_rx_data", 32'(rx_data), 32'h00);
    check("arst_underrun", 32'(tx_underrun), 32'd0);
    cs_n_i = 1'b1;
    sck_i  = 1'b0;
    mosi_i = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("arst_no_rx", 32'(rx_cnt - rx0), 32'd0);

    // Write coincident with the CS-fall load while the register is empty
    rx0 = rx_cnt; und0 = und_cnt;
    @(negedge clk);
    cs_n_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    tx_data  = 8'h5A;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    check("same_cyc_underrun", 32'(tx_underrun), 32'd1);
    check("same_cyc_tx_ready", 32'(tx_ready), 32'd0);
    repeat (3) @(negedge clk);
    shift_bits(8'h00, 8, 1, mi);
    shift_bits(8'hC3, 8, 0, mi2);
    repeat (4) @(negedge clk);
    check("same_cyc_miso_byte1", 32'(mi), 32'h00);
    check("same_cyc_miso_byte2", 32'(mi2), 32'h5A);
    check("same_cyc_underrun_count", 32'(und_cnt - und0), 32'd1);
    check("same_cyc_rx_count", 32'(rx_cnt - rx0), 32'd2);
    check("same_cyc_rx_byte2", 32'(rx_last), 32'hC3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_target_xcvr.md
SPI_TARGET_XCVR -- requirements
Module: spi_target_xcvr

Interface
REQ-001 Parameter SYNC_STAGES, default 2: synchronizer depth on sck_i, mosi_i and cs_n_i (legal values 2..3).
REQ-002 clk  input  1  system clock; all state on its rising edge; frequency SHALL be at least 8x SCK.
REQ-003 rst_n  input  1  reset; asynchronous assert, active-low.
REQ-004 sck_i  input  1  SPI clock from the controller, mode 0 (CPOL=0, CPHA=0).
REQ-005 cs_n_i  input  1  chip select, active-low.
REQ-006 mosi_i  input  1  serial data in, MSB first.
REQ-007 miso_o  output  1  serial data out, MSB first.
REQ-008 miso_oe_o  output  1  output enable for MISO; high only while selected.
REQ-009 tx_data  input  8  next byte to transmit.
REQ-010 tx_valid  input  1  tx_data valid.
REQ-011 tx_ready  output  1  one-entry TX holding register is empty.
REQ-012 rx_data  output  8  last complete received byte.
REQ-013 rx_valid  output  1  one-cycle pulse: rx_data updated.
REQ-014 tx_underrun  output  1  one-cycle pulse: byte load found holding register empty.

Function
REQ-015 sck_i, cs_n_i and mosi_i SHALL pass SYNC_STAGES flip-flops; edges SHALL be detected on synchronized SCK against a one-cycle-delayed copy.
REQ-016 FSM states: IDLE (cs high), ACTIVE (cs low); IDLE->ACTIVE on synchronized cs falling; ACTIVE->IDLE on synchronized cs rising.
REQ-017 IDLE->ACTIVE: bit_cnt cleared; TX shift register loaded from the holding register, which is then emptied; miso_o shows bit 7 the next cycle.
REQ-018 Holding register empty at any load: shift register loads 0x00 and tx_underrun pulses for one cycle.
REQ-019 Synchronized SCK rising in ACTIVE: shift mosi into RX register LSB-side; bit_cnt increments mod 8.
REQ-020 On the rising edge that takes bit_cnt 7->0: rx_data SHALL take the full byte and rx_valid SHALL pulse exactly once.
REQ-021 rx_valid latency: SYNC_STAGES+1 clk cycles after the raw sck_i rising edge (3 at default).
REQ-022 Synchronized SCK falling in ACTIVE: bit_cnt==0 -> reload (REQ-017/018 rules) for the next byte; otherwise shift TX left one bit.
REQ-023 miso_o = TX shift bit 7 in ACTIVE, 0 in IDLE; miso_oe_o = 1 in ACTIVE only.
REQ-024 tx_ready = holding register empty; tx_valid && tx_ready writes it; tx_valid with tx_ready low is ignored.
REQ-025 Write and load in the same cycle: the load sees the pre-write state (empty -> 0x00 + underrun); the write fills the register for the following byte.
REQ-026 cs_n rises mid-byte: partial RX bits discarded, no rx_valid, bit_cnt cleared, TX shift contents discarded; holding register preserved.
REQ-027 SCK edges while IDLE SHALL have no effect.
REQ-028 Back-to-back bytes under continuous cs low SHALL need no idle SCK periods between them.

Reset
REQ-029 rst_n low SHALL asynchronously clear: FSM=IDLE, bit_cnt=0, shift registers=0, holding register empty (tx_ready=1), rx_data=0x00, rx_valid=0, tx_underrun=0, miso_o=0, miso_oe_o=0; synchronizers preset to cs_n=1, sck=0, mosi=0.
REQ-030 Reset asserted mid-transfer SHALL abort the transfer with no rx_valid pulse.

Verification
REQ-031 Preload tx 0xA5; cs low; 8 SCK at clk/8; MOSI 0x3C -> MISO bits 1,0,1,0,0,1,0,1; one rx_valid with rx_data 0x3C; tx_ready back to 1 after cs fall.
REQ-032 No tx write; transfer one byte -> MISO all 0; exactly one tx_underrun pulse at cs fall.
REQ-033 Preload 0x11; write 0x22 during byte 1; two bytes under one cs, MOSI 0xDE,0xAD -> MISO 0x11 then 0x22; rx_valid pulses with 0xDE then 0xAD.
REQ-034 cs raised after 5 SCK -> no rx_valid; next full transfer receives its byte intact.
REQ-035 rst_n low after 4 bits -> all outputs at reset values within the same cycle, with no clock edge required.
REQ-036 tx write in the same cycle as the cs-fall load with register empty -> underrun pulse, 0x00 sent, written byte sent as byte 2.
